// File: rtl/conf_bridge_pkg.sv
// conf_bridge_pkg: shared types and constants for the configuration-register bridge.
package conf_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } conf_bridge_state_t;

  localparam int          CONF_OFFSET_W     = 16;
  localparam logic [31:0] CONF_BASE_DEFAULT = 32'h1faf_0000;
  localparam logic [31:0] CONF_MASK_DEFAULT = 32'hffff_0000;

endpackage

// File: rtl/conf_bridge.sv
// conf_bridge: single-outstanding SRAM-like initiator for the board config-register port.
// Accepts one request, issues a one-cycle conf_en strobe with the 16-bit offset, waits
// READ_LATENCY cycles for read data, then presents the response until it is taken.
// Optional macro CONF_BRIDGE_RANGE_CHECK_EN: requests outside BASE_ADDR/ADDR_MASK are
// answered with resp_err=1 and never reach the register port.
module conf_bridge
  import conf_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = CONF_BASE_DEFAULT,
  parameter logic [31:0] ADDR_MASK    = CONF_MASK_DEFAULT,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        conf_en,
  output logic [3:0]  conf_wen,
  output logic [31:0] conf_addr,
  output logic [31:0] conf_wdata,
  input  logic [31:0] conf_rdata
);

  // Counter load value: WAIT lasts READ_LATENCY cycles, ending on the count of zero.
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  conf_bridge_state_t state_reg;
  logic [1:0]         lat_cnt_reg;
  logic [3:0]         wstrb_reg;
  logic               out_of_range;

`ifdef CONF_BRIDGE_RANGE_CHECK_EN
  assign out_of_range = (req_addr & ADDR_MASK) != BASE_ADDR;
`else
  // Upper address bits and the window parameters are intentionally ignored here.
  logic unused_window;
  assign unused_window = ^{req_addr[31:CONF_OFFSET_W], BASE_ADDR, ADDR_MASK};
  assign out_of_range  = 1'b0;
`endif

  // Only IDLE takes a request; depends on state alone, never on resp_ready.
  assign req_ready = (state_reg == IDLE);

  // Transaction FSM with registered bus and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= 2'd0;
      wstrb_reg   <= 4'd0;
      conf_en     <= 1'b0;
      conf_wen    <= 4'd0;
      conf_addr   <= 32'd0;
      conf_wdata  <= 32'd0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            wstrb_reg  <= req_wstrb;
            conf_addr  <= {{(32 - CONF_OFFSET_W){1'b0}}, req_addr[CONF_OFFSET_W-1:0]};
            conf_wdata <= req_wdata;
            if (out_of_range) begin
              // Rejected request: answer straight away, the register port stays quiet.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              state_reg  <= RESP;
            end else begin
              conf_en   <= 1'b1;
              conf_wen  <= req_wstrb;
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          conf_en  <= 1'b0;
          conf_wen <= 4'd0;
          if (wstrb_reg != 4'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            state_reg  <= RESP;
          end else begin
            lat_cnt_reg <= LAT_LOAD;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt_reg == 2'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= conf_rdata;
            resp_err   <= 1'b0;
            state_reg  <= RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_bridge.sv
// tb_conf_bridge: randomized and directed checks of conf_bridge at READ_LATENCY 1 and 3.
module tb_conf_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_h
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata = '0;

    conf_bridge #(
      .BASE_ADDR(32'h1faf_0000),
      .ADDR_MASK(32'hffff_0000),
      .READ_LATENCY(LAT)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .conf_en(conf_en), .conf_wen(conf_wen), .conf_addr(conf_addr),
      .conf_wdata(conf_wdata), .conf_rdata(conf_rdata)
    );

    // Register-block responder: data valid only in the cycle LAT after the strobe cycle.
    logic [31:0] next_rdata = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wen = '0;
    int k = 0;
    int en_cnt = 0;
    always @(posedge clk) begin
      if (rst) k = 0;
      else if (conf_en) begin
        k = 1;
        en_cnt++;
        last_addr = conf_addr;
        last_wdata = conf_wdata;
        last_wen = conf_wen;
      end else if (k > 0 && k < 8) k++;
      #1;
      conf_rdata = (k == LAT) ? next_rdata : $urandom;
    end

    // Behavioural model: transaction-level timeline, compared on every falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          act = 0;
    int          t0, dlat;
    logic [31:0] m_addr, m_wdata, m_rd;
    logic [3:0]  m_wstrb;
    bit          m_in;
    always @(negedge clk) begin
      int d;
      if (rst) act = 0;
      else if (!act) begin
        chk($sformatf("L%0d idle req_ready", LAT), 32'(req_ready), 32'd1);
        chk($sformatf("L%0d idle conf_en", LAT), 32'(conf_en), 32'd0);
        chk($sformatf("L%0d idle resp_valid", LAT), 32'(resp_valid), 32'd0);
        if (req_valid) begin
          act = 1; t0 = cyc;
          m_addr = req_addr; m_wstrb = req_wstrb; m_wdata = req_wdata; m_rd = next_rdata;
`ifdef CONF_BRIDGE_RANGE_CHECK_EN
          m_in = (req_addr >> 16) == 32'h1faf;
`else
          m_in = 1;
`endif
          dlat = !m_in ? 1 : (req_wstrb != 0) ? 2 : 2 + LAT;
        end
      end else begin
        d = cyc - t0;
        chk($sformatf("L%0d busy req_ready d=%0d", LAT, d), 32'(req_ready), 32'd0);
        chk($sformatf("L%0d conf_en d=%0d", LAT, d), 32'(conf_en), 32'(m_in && d == 1));
        if (m_in) chk($sformatf("L%0d conf_addr d=%0d", LAT, d), conf_addr, m_addr % 65536);
        if (m_in && d == 1) begin
          chk($sformatf("L%0d conf_wen", LAT), 32'(conf_wen), 32'(m_wstrb));
          chk($sformatf("L%0d conf_wdata", LAT), conf_wdata, m_wdata);
        end
        chk($sformatf("L%0d resp_valid d=%0d", LAT, d), 32'(resp_valid), 32'(d >= dlat));
        if (d >= dlat) begin
          chk($sformatf("L%0d resp_rdata d=%0d", LAT, d), resp_rdata,
              (m_in && m_wstrb == 0) ? m_rd : 32'd0);
          chk($sformatf("L%0d resp_err d=%0d", LAT, d), 32'(resp_err), 32'(!m_in));
          if (resp_ready) act = 0;
        end
      end
    end

    // One request/response exchange; call at posedge+1. lat counts cycles after the accept edge.
    task automatic run_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] dw,
                           input logic [31:0] rd_val, input int hold, input bit keep,
                           output int lat, output logic [31:0] rd, output logic er);
      int h;
      bit acc, got;
      next_rdata = rd_val;
      req_addr = a; req_wstrb = s; req_wdata = dw; req_valid = 1; resp_ready = 0;
      acc = 0;
      for (int n = 0; n < 20 && !acc; n++) begin
        @(negedge clk); acc = req_ready;
        @(posedge clk); #1;
      end
      if (!acc) chk($sformatf("L%0d accept timeout", LAT), 32'd0, 32'd1);
      if (!keep) req_valid = 0;
      got = 0; h = 0; lat = -1; rd = 0; er = 0;
      for (int n = 1; n < 40 && !got; n++) begin
        resp_ready = (h >= hold);
        @(negedge clk);
        if (resp_valid) begin
          if (lat < 0) lat = n;
          if (resp_ready) begin got = 1; rd = resp_rdata; er = resp_err; end
          else h++;
        end
        @(posedge clk); #1;
      end
      req_valid = 0; resp_ready = 0;
      if (!got) chk($sformatf("L%0d response timeout", LAT), 32'd0, 32'd1);
    endtask

    initial begin
      int lat, e0;
      logic [31:0] rd;
      logic er;
      // Reset state
      @(posedge clk); #1;
      chk($sformatf("L%0d rst conf_en", LAT), 32'(conf_en), 32'd0);
      chk($sformatf("L%0d rst resp_valid", LAT), 32'(resp_valid), 32'd0);
      chk($sformatf("L%0d rst conf_addr", LAT), conf_addr, 32'd0);
      @(posedge clk); #1; rst = 0;
      @(posedge clk); #1;

      // Directed write
      e0 = en_cnt;
      run_txn(32'h1faf_0000, 4'hf, 32'h0000_00a5, 32'd0, 0, 0, lat, rd, er);
      chk($sformatf("L%0d wr latency", LAT), 32'(lat), 32'd2);
      chk($sformatf("L%0d wr strobes", LAT), 32'(en_cnt - e0), 32'd1);
      chk($sformatf("L%0d wr addr", LAT), last_addr, 32'd0);
      chk($sformatf("L%0d wr wen", LAT), 32'(last_wen), 32'hf);
      chk($sformatf("L%0d wr wdata", LAT), last_wdata, 32'ha5);
      chk($sformatf("L%0d wr rdata", LAT), rd, 32'd0);

      // Directed read
      run_txn(32'h1faf_000c, 4'h0, 32'd0, 32'h0000_003c, 0, 0, lat, rd, er);
      chk($sformatf("L%0d rd latency", LAT), 32'(lat), (LAT == 1) ? 32'd3 : 32'd5);
      chk($sformatf("L%0d rd data", LAT), rd, 32'h3c);
      chk($sformatf("L%0d rd addr", LAT), last_addr, 32'hc);

      // Back-pressure with req_valid held high
      e0 = en_cnt;
      run_txn(32'h1faf_0004, 4'h0, 32'd0, 32'h0000_1234, 4, 1, lat, rd, er);
      chk($sformatf("L%0d hold strobes", LAT), 32'(en_cnt - e0), 32'd1);
      chk($sformatf("L%0d hold data", LAT), rd, 32'h1234);

      // Write outside the window
      e0 = en_cnt;
      run_txn(32'h1fb0_0000, 4'hf, 32'h55, 32'd0, 0, 0, lat, rd, er);
`ifdef CONF_BRIDGE_RANGE_CHECK_EN
      chk($sformatf("L%0d oor latency", LAT), 32'(lat), 32'd1);
      chk($sformatf("L%0d oor err", LAT), 32'(er), 32'd1);
      chk($sformatf("L%0d oor strobes", LAT), 32'(en_cnt - e0), 32'd0);
`else
      chk($sformatf("L%0d oor latency", LAT), 32'(lat), 32'd2);
      chk($sformatf("L%0d oor err", LAT), 32'(er), 32'd0);
      chk($sformatf("L%0d oor strobes", LAT), 32'(en_cnt - e0), 32'd1);
      chk($sformatf("L%0d oor addr", LAT), last_addr, 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 30; i++) begin
        logic [31:0] a;
        logic [3:0] s;
        a = ($urandom_range(0, 9) < 7) ? {16'h1faf, 16'($urandom) & 16'hfffc} : $urandom;
        s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        run_txn(a, s, $urandom, $urandom, $urandom_range(0, 3), 0, lat, rd, er);
      end

      // Reset while a read sits in WAIT
      next_rdata = 32'hdead_beef;
      req_addr = 32'h1faf_0008; req_wstrb = 4'h0; req_valid = 1;
      @(negedge clk);
      chk($sformatf("L%0d rw ready", LAT), 32'(req_ready), 32'd1);
      @(posedge clk); #1; req_valid = 0;  // cycle 1: ISSUE
      @(posedge clk); #1;                 // cycle 2: WAIT
      rst = 1; #1;
      chk($sformatf("L%0d rw conf_en", LAT), 32'(conf_en), 32'd0);
      chk($sformatf("L%0d rw resp_valid", LAT), 32'(resp_valid), 32'd0);
      chk($sformatf("L%0d rw resp_rdata", LAT), resp_rdata, 32'd0);
      chk($sformatf("L%0d rw conf_addr", LAT), conf_addr, 32'd0);
      @(posedge clk); #1; rst = 0;
      @(negedge clk);
      chk($sformatf("L%0d post-rst ready", LAT), 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      e0 = en_cnt;
      run_txn(32'h1faf_0010, 4'h3, 32'h0000_beef, 32'd0, 0, 0, lat, rd, er);
      chk($sformatf("L%0d post-rst wr latency", LAT), 32'(lat), 32'd2);
      chk($sformatf("L%0d post-rst strobes", LAT), 32'(en_cnt - e0), 32'd1);
      chk($sformatf("L%0d post-rst wdata", LAT), last_wdata, 32'hbeef);
      done_cnt++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && done_cnt < 2; i++) @(posedge clk);
    if (done_cnt < 2) chk("global timeout", 32'(done_cnt), 32'd2);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
